// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared types and constants for the packet-aware AXI-stream arbiter.
package axis_pkt_arbiter_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // One-hot owner encodings; the FSM state is encoded the same way so grant is a plain copy.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M1   = 2'b01;
  localparam logic [1:0] GRANT_M2   = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = GRANT_NONE,
    StOwnM1 = GRANT_M1,
    StOwnM2 = GRANT_M2
  } arb_state_e;

endpackage

// File: rtl/axis_pkt_arbiter_skid.sv
// Two-entry registered skid buffer. Ready and valid both come straight from flops so
// neither side sees a combinational path through the other. Only entry 0 drives the output.
module axis_skid_buffer
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Occupancy and storage update; entry 1 only ever shifts forward into entry 0.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          data0_d = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b11: data0_d = in_data;
          2'b10: begin
            data1_d = in_data;
            count_d = 2'd2;
          end
          2'b01: count_d = 2'd0;
          default: ;
        endcase
      end
      2'd2: begin
        // push cannot happen here because in_ready_q is low when full
        if (pop) begin
          data0_d = data1_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // State registers; the handshake flags are registered views of the next occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      data0_q     <= '0;
      data1_q     <= '0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      count_q     <= count_d;
      in_ready_q  <= (count_d != 2'd2);
      out_valid_q <= (count_d != 2'd0);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data0_q;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-aware round-robin arbiter for two AXI-stream masters. A grant is taken in IDLE
// (registered, one cycle of latency) and held until the owner's last beat is accepted.
module axis_pkt_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned MAX_BEATS  = 16,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] m1_data_in,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_last,
  input  logic [DATA_WIDTH-1:0] m2_data_in,
  input  logic                  m2_valid,
  output logic                  m2_ready,
  input  logic                  m2_last,
  output logic [DATA_WIDTH-1:0] s_data_out,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic                  s_last,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  len_err
);

  arb_state_e           state_q, state_d;
  logic                 last_m2_q, last_m2_d;  // 1: M2 won last, so M1 wins the next tie
  logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic                 len_err_q, len_err_d;

  logic                  skid_in_valid;
  logic                  skid_in_ready;
  logic [DATA_WIDTH:0]   skid_in_data;
  logic [DATA_WIDTH:0]   skid_out_data;
  logic                  accept;
  logic                  acc_last;

  // Arbitration, owner muxing and beat accounting.
  always_comb begin
    state_d       = state_q;
    last_m2_d     = last_m2_q;
    beat_count_d  = beat_count_q;
    len_err_d     = len_err_q;
    skid_in_valid = 1'b0;
    skid_in_data  = '0;
    m1_ready      = 1'b0;
    m2_ready      = 1'b0;
    acc_last      = 1'b0;
    accept        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (m1_valid && m2_valid) begin
          state_d = last_m2_q ? StOwnM1 : StOwnM2;
        end else if (m1_valid) begin
          state_d = StOwnM1;
        end else if (m2_valid) begin
          state_d = StOwnM2;
        end
        if (state_d != StIdle) begin
          beat_count_d = '0;
        end
      end
      StOwnM1: begin
        skid_in_valid = m1_valid;
        skid_in_data  = {m1_last, m1_data_in};
        m1_ready      = skid_in_ready;
        acc_last      = m1_last;
        if (m1_valid && skid_in_ready && m1_last) begin
          last_m2_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StOwnM2: begin
        skid_in_valid = m2_valid;
        skid_in_data  = {m2_last, m2_data_in};
        m2_ready      = skid_in_ready;
        acc_last      = m2_last;
        if (m2_valid && skid_in_ready && m2_last) begin
          last_m2_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    accept = skid_in_valid & skid_in_ready;
    if (accept) begin
      if (beat_count_q != '1) begin
        beat_count_d = beat_count_q + 1'b1;
      end
      // Only a non-last beat reaching the limit means the packet is over length.
      if (!acc_last && (beat_count_d == CNT_WIDTH'(MAX_BEATS))) begin
        len_err_d = 1'b1;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_m2_q    <= 1'b1;
      beat_count_q <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_m2_q    <= last_m2_d;
      beat_count_q <= beat_count_d;
      len_err_q    <= len_err_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .in_data  (skid_in_data),
    .out_valid(s_valid),
    .out_ready(s_ready),
    .out_data (skid_out_data)
  );

  assign s_data_out = skid_out_data[DATA_WIDTH-1:0];
  assign s_last     = skid_out_data[DATA_WIDTH];
  assign grant      = 2'(state_q);
  assign beat_count = beat_count_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter.
module tb_axis_pkt_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] m1_data_in, m2_data_in, s_data_out;
  logic       m1_valid, m1_ready, m1_last;
  logic       m2_valid, m2_ready, m2_last;
  logic       s_valid, s_ready, s_last;
  logic [1:0] grant;
  logic [4:0] beat_count;
  logic       len_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int occ      = 0;
  int in_acc   = 0;
  logic [8:0] out_q[$];
  int         out_t[$];

  always #5 clk = ~clk;

  axis_pkt_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m1_data_in(m1_data_in),
    .m1_valid  (m1_valid),
    .m1_ready  (m1_ready),
    .m1_last   (m1_last),
    .m2_data_in(m2_data_in),
    .m2_valid  (m2_valid),
    .m2_ready  (m2_ready),
    .m2_last   (m2_last),
    .s_data_out(s_data_out),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .grant     (grant),
    .beat_count(beat_count),
    .len_err   (len_err)
  );

  // Slave-side capture and bench-side occupancy model.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      occ <= 0;
    end else begin
      if (s_valid && s_ready) begin
        out_q.push_back({s_last, s_data_out});
        out_t.push_back(cyc);
      end
      occ <= occ + (((m1_valid && m1_ready) || (m2_valid && m2_ready)) ? 1 : 0)
                 - ((s_valid && s_ready) ? 1 : 0);
      if ((m1_valid && m1_ready) || (m2_valid && m2_ready)) in_acc <= in_acc + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1);
  end

  task automatic m1_send(input int n, input logic [7:0] base, input bit inc);
    for (int i = 0; i < n; i++) begin
      int g;
      bit acc;
      g = 0;
      acc = 1'b0;
      m1_valid = 1'b1;
      m1_data_in = inc ? base + 8'(i) : base;
      m1_last = (i == n - 1);
      while (!acc) begin
        @(negedge clk);
        acc = m1_ready;
        @(posedge clk);
        #1;
        g++;
        if (!acc && g > 200) begin
          n_checks++;
          $display("FAIL m1_send_timeout beat %0d: accepted 0, required 1", i);
          m1_valid = 1'b0;
          return;
        end
      end
    end
    m1_valid = 1'b0;
    m1_last  = 1'b0;
  endtask

  task automatic m2_send(input int n, input logic [7:0] base, input bit inc);
    for (int i = 0; i < n; i++) begin
      int g;
      bit acc;
      g = 0;
      acc = 1'b0;
      m2_valid = 1'b1;
      m2_data_in = inc ? base + 8'(i) : base;
      m2_last = (i == n - 1);
      while (!acc) begin
        @(negedge clk);
        acc = m2_ready;
        @(posedge clk);
        #1;
        g++;
        if (!acc && g > 200) begin
          n_checks++;
          $display("FAIL m2_send_timeout beat %0d: accepted 0, required 1", i);
          m2_valid = 1'b0;
          return;
        end
      end
    end
    m2_valid = 1'b0;
    m2_last  = 1'b0;
  endtask

  task automatic clear_out();
    out_q.delete();
    out_t.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m1_valid = 0; m1_last = 0; m1_data_in = 8'h00;
    m2_valid = 0; m2_last = 0; m2_data_in = 8'h00;
    s_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
    n_checks++; if (m1_ready !== 1'b0) $display("FAIL reset_m1_ready: got %b want 0", m1_ready); else n_pass++;
    n_checks++; if (m2_ready !== 1'b0) $display("FAIL reset_m2_ready: got %b want 0", m2_ready); else n_pass++;
    n_checks++; if (s_valid !== 1'b0) $display("FAIL reset_s_valid: got %b want 0", s_valid); else n_pass++;
    n_checks++; if (s_last !== 1'b0) $display("FAIL reset_s_last: got %b want 0", s_last); else n_pass++;
    n_checks++; if (s_data_out !== 8'h00) $display("FAIL reset_s_data: got %h want 00", s_data_out); else n_pass++;
    n_checks++; if (beat_count !== 5'd0) $display("FAIL reset_beat_count: got %0d want 0", beat_count); else n_pass++;
    n_checks++; if (len_err !== 1'b0) $display("FAIL reset_len_err: got %b want 0", len_err); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_m1_only();
    logic [8:0] exp [3];
    exp[0] = {1'b0, 8'h3e}; exp[1] = {1'b0, 8'h3f}; exp[2] = {1'b1, 8'h40};
    clear_out();
    s_ready = 1'b1;
    m1_valid = 1'b1; m1_data_in = 8'h3e; m1_last = 1'b0;
    @(negedge clk);
    n_checks++; if (grant !== 2'b00) $display("FAIL m1_grant_latency: got %b want 00", grant); else n_pass++;
    n_checks++; if (m1_ready !== 1'b0) $display("FAIL m1_ready_latency: got %b want 0", m1_ready); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (grant !== 2'b01) $display("FAIL m1_grant: got %b want 01", grant); else n_pass++;
    m1_send(3, 8'h3e, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (grant !== 2'b00) $display("FAIL m1_grant_release: got %b want 00", grant); else n_pass++;
    n_checks++; if (beat_count !== 5'd3) $display("FAIL m1_beat_count: got %0d want 3", beat_count); else n_pass++;
    n_checks++; if (out_q.size() !== 3) $display("FAIL m1_out_count: got %0d want 3", out_q.size()); else n_pass++;
    if (out_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (out_q[i] !== exp[i]) $display("FAIL m1_out_beat%0d: got %h want %h", i, out_q[i], exp[i]);
        else n_pass++;
      end
      n_checks++;
      if (out_t[2] - out_t[0] !== 2) $display("FAIL m1_out_consecutive: got span %0d want 2", out_t[2] - out_t[0]);
      else n_pass++;
    end
  endtask

  task automatic test_tie_and_round_robin();
    logic [8:0] exp [4];
    exp[0] = {1'b0, 8'h3e}; exp[1] = {1'b1, 8'h3e}; exp[2] = {1'b0, 8'h4f}; exp[3] = {1'b1, 8'h4f};
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_out();
    s_ready = 1'b1;
    fork
      m1_send(2, 8'h3e, 1'b0);
      m2_send(2, 8'h4f, 1'b0);
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_q.size() !== 4) $display("FAIL tie_out_count: got %0d want 4", out_q.size()); else n_pass++;
    if (out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (out_q[i] !== exp[i]) $display("FAIL tie_out_beat%0d: got %h want %h", i, out_q[i], exp[i]);
        else n_pass++;
      end
      n_checks++;
      if (out_t[2] - out_t[1] !== 2) $display("FAIL tie_idle_bubble: got gap %0d want 2", out_t[2] - out_t[1]);
      else n_pass++;
    end
    clear_out();
    fork
      m1_send(1, 8'h11, 1'b0);
      m2_send(1, 8'h22, 1'b0);
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_q.size() !== 2) $display("FAIL rr_out_count: got %0d want 2", out_q.size()); else n_pass++;
    if (out_q.size() == 2) begin
      n_checks++; if (out_q[0] !== {1'b1, 8'h11}) $display("FAIL rr_first: got %h want 111", out_q[0]); else n_pass++;
      n_checks++; if (out_q[1] !== {1'b1, 8'h22}) $display("FAIL rr_second: got %h want 122", out_q[1]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int full_seen;
    int bad;
    full_seen = 0;
    clear_out();
    s_ready = 1'b1;
    fork
      m2_send(6, 8'h50, 1'b1);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (occ == 2) begin
          full_seen++;
          n_checks++;
          if (m2_ready !== 1'b0) $display("FAIL bp_ready_when_full cycle %0d: got %b want 0", c, m2_ready);
          else n_pass++;
        end
        @(posedge clk);
        #1;
        if (c % 2 == 1) s_ready = ~s_ready;
      end
    join
    s_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (full_seen == 0) $display("FAIL bp_full_reached: got 0 full cycles, want >0"); else n_pass++;
    n_checks++; if (out_q.size() !== 6) $display("FAIL bp_out_count: got %0d want 6", out_q.size()); else n_pass++;
    if (out_q.size() == 6) begin
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        if (out_q[i] !== {(i == 5), 8'h50 + 8'(i)}) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL bp_out_order: got %0d wrong beats want 0", bad); else n_pass++;
    end
  endtask

  task automatic test_len_err();
    int base;
    int g;
    int bad;
    clear_out();
    s_ready = 1'b1;
    base = in_acc;
    n_checks++; if (len_err !== 1'b0) $display("FAIL len_err_before: got %b want 0", len_err); else n_pass++;
    fork
      m1_send(18, 8'h60, 1'b1);
      begin
        g = 0;
        while ((in_acc - base) < 15 && g < 300) begin @(negedge clk); g++; end
        n_checks++; if (len_err !== 1'b0) $display("FAIL len_err_beat15: got %b want 0", len_err); else n_pass++;
        g = 0;
        while ((in_acc - base) < 16 && g < 300) begin @(negedge clk); g++; end
        n_checks++; if (len_err !== 1'b1) $display("FAIL len_err_beat16: got %b want 1", len_err); else n_pass++;
      end
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (len_err !== 1'b1) $display("FAIL len_err_sticky: got %b want 1", len_err); else n_pass++;
    n_checks++; if (beat_count !== 5'd18) $display("FAIL len_beat_count: got %0d want 18", beat_count); else n_pass++;
    n_checks++; if (out_q.size() !== 18) $display("FAIL len_out_count: got %0d want 18", out_q.size()); else n_pass++;
    if (out_q.size() == 18) begin
      bad = 0;
      for (int i = 0; i < 18; i++) begin
        if (out_q[i] !== {(i == 17), 8'h60 + 8'(i)}) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL len_out_data: got %0d wrong beats want 0", bad); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    int g;
    clear_out();
    s_ready = 1'b0;
    base = in_acc;
    m1_valid = 1'b1; m1_data_in = 8'h70; m1_last = 1'b0;
    g = 0;
    while ((in_acc - base) < 2 && g < 50) begin @(posedge clk); #1; g++; end
    n_checks++; if (occ !== 2) $display("FAIL rst_mid_buffered: got %0d want 2", occ); else n_pass++;
    reset = 1'b1;
    m1_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (s_valid !== 1'b0) $display("FAIL rst_mid_s_valid: got %b want 0", s_valid); else n_pass++;
    n_checks++; if (grant !== 2'b00) $display("FAIL rst_mid_grant: got %b want 00", grant); else n_pass++;
    n_checks++; if (beat_count !== 5'd0) $display("FAIL rst_mid_beat_count: got %0d want 0", beat_count); else n_pass++;
    n_checks++; if (len_err !== 1'b0) $display("FAIL rst_mid_len_err: got %b want 0", len_err); else n_pass++;
    @(posedge clk);
    #1;
    s_ready = 1'b1;
    fork
      m1_send(1, 8'h71, 1'b0);
      m2_send(1, 8'h72, 1'b0);
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_q.size() !== 2) $display("FAIL rst_mid_out_count: got %0d want 2", out_q.size()); else n_pass++;
    if (out_q.size() == 2) begin
      n_checks++; if (out_q[0] !== {1'b1, 8'h71}) $display("FAIL rst_mid_m1_first: got %h want 171", out_q[0]); else n_pass++;
    end
  endtask

  task automatic test_m2_stall();
    int g;
    bit acc;
    clear_out();
    s_ready = 1'b1;
    m2_valid = 1'b1; m2_data_in = 8'h80; m2_last = 1'b0;
    acc = 1'b0; g = 0;
    while (!acc && g < 50) begin @(negedge clk); acc = m2_ready; @(posedge clk); #1; g++; end
    m2_valid = 1'b0;
    m1_valid = 1'b1; m1_data_in = 8'h90; m1_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (grant !== 2'b10) $display("FAIL stall_grant cycle %0d: got %b want 10", c, grant); else n_pass++;
      n_checks++; if (m1_ready !== 1'b0) $display("FAIL stall_m1_ready cycle %0d: got %b want 0", c, m1_ready); else n_pass++;
      @(posedge clk);
      #1;
    end
    m2_valid = 1'b1; m2_data_in = 8'h81; m2_last = 1'b1;
    acc = 1'b0; g = 0;
    while (!acc && g < 50) begin
      @(negedge clk);
      if (m1_ready !== 1'b0) begin
        n_checks++;
        $display("FAIL stall_m1_ready_before_last: got %b want 0", m1_ready);
      end
      acc = m2_ready;
      @(posedge clk);
      #1;
      g++;
    end
    m2_valid = 1'b0; m2_last = 1'b0;
    n_checks++; if (grant !== 2'b00) $display("FAIL stall_release_grant: got %b want 00", grant); else n_pass++;
    acc = 1'b0; g = 0;
    while (!acc && g < 50) begin @(negedge clk); acc = m1_ready; @(posedge clk); #1; g++; end
    m1_valid = 1'b0; m1_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_q.size() !== 3) $display("FAIL stall_out_count: got %0d want 3", out_q.size()); else n_pass++;
    if (out_q.size() == 3) begin
      n_checks++; if (out_q[0] !== {1'b0, 8'h80}) $display("FAIL stall_out0: got %h want 080", out_q[0]); else n_pass++;
      n_checks++; if (out_q[1] !== {1'b1, 8'h81}) $display("FAIL stall_out1: got %h want 181", out_q[1]); else n_pass++;
      n_checks++; if (out_q[2] !== {1'b1, 8'h90}) $display("FAIL stall_out2: got %h want 190", out_q[2]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_m1_only();
    test_tie_and_round_robin();
    test_backpressure();
    test_len_err();
    test_reset_mid_packet();
    test_m2_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Packet-aware round-robin arbiter for two 8-bit AXI-stream masters sharing one slave port.
- Replaces the free-running external select used with mux_axi. A grant is held from the first beat of a packet until its last beat.
- Output goes through a registered 2-entry skid stage, so slave-side timing is decoupled from arbitration.

Parameters:
- DATA_WIDTH, 8, width of all data buses
- MAX_BEATS, 16, packet length above which len_err is flagged (no truncation)
- CNT_WIDTH, 5, width of beat_count; must hold MAX_BEATS+1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- m1_data_in  input  DATA_WIDTH  master 1 data
- m1_valid  input  1  master 1 valid
- m1_ready  output  1  master 1 ready
- m1_last  input  1  master 1 end of packet
- m2_data_in  input  DATA_WIDTH  master 2 data
- m2_valid  input  1  master 2 valid
- m2_ready  output  1  master 2 ready
- m2_last  input  1  master 2 end of packet
- s_data_out  output  DATA_WIDTH  slave data
- s_valid  output  1  slave valid
- s_ready  input  1  slave ready
- s_last  output  1  slave end of packet
- grant  output  2  one-hot current owner: 01 = M1, 10 = M2, 00 = idle
- beat_count  output  CNT_WIDTH  beats accepted in the current packet, saturating
- len_err  output  1  sticky flag: a packet exceeded MAX_BEATS

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. A reset asserted mid-packet aborts the packet and flushes the skid stage.
- Reset values:
  - state IDLE, last_winner = M2 (so M1 wins the first tie)
  - grant 00, m1_ready 0, m2_ready 0
  - s_valid 0, s_last 0, s_data_out 0
  - beat_count 0, len_err 0
- FSM states: IDLE, OWN_M1, OWN_M2.
- IDLE transitions:
  - only m1_valid: go to OWN_M1
  - only m2_valid: go to OWN_M2
  - both valid: grant the master that is not last_winner
  - neither: stay in IDLE
  - Grant is registered: one cycle of arbitration latency from valid seen to ready.
- OWN_X:
  - mX_ready = skid in_ready; the other master's ready is held at 0.
  - A beat is accepted when mX_valid & mX_ready.
  - On an accepted beat with mX_last=1: last_winner <= X, next state IDLE. This gives exactly one idle bubble between packets.
  - mX_valid dropping mid-packet does not release the grant; the arbiter waits.
- grant output equals the state encoding.
- beat_count:
  - cleared on entry to OWN_X
  - incremented per accepted beat, saturating at all-ones
  - holds its value in IDLE until the next grant
- len_err:
  - set when an accepted non-last beat makes beat_count == MAX_BEATS
  - stays set until reset
  - the stream itself is unaffected
- Skid stage (2 entries):
  - in_ready = registered "not full"
  - s_valid = registered "not empty"
  - sustains 1 beat per cycle while s_ready=1
  - latency: a beat accepted at edge N is visible on s_data_out/s_last after edge N
  - with s_ready=0, at most 2 beats are buffered and then in_ready drops
  - simultaneous push and pop when full is impossible, because in_ready=0
  - simultaneous push and pop when holding 1 entry leaves the occupancy unchanged
- s_data_out/s_last stay stable while s_valid & ~s_ready.
- Only entry 0 is presented on the output; data is never reordered.

Decomposition:
- Shared package:
  - state typedef (IDLE/OWN_M1/OWN_M2)
  - grant encodings GRANT_NONE=2'b00, GRANT_M1=2'b01, GRANT_M2=2'b10
  - default DATA_WIDTH
- Sub-module axis_skid_buffer (DATA_WIDTH+1 bits, carries last): clk, reset, in_valid/in_ready/in_data, out_valid/out_ready/out_data. It is reusable elsewhere.
- The arbiter FSM, counter and output muxing stay in the top level.

Test Plan:
- Reset, then M1 only, 3-beat packet 8'h3e,8'h3f,8'h40 (last on the third beat), s_ready=1 -> grant=01 one cycle after valid; s_data_out shows 3e,3f,40 on consecutive cycles with s_last on 40; beat_count=3; grant returns to 00.
- Both valid at the first cycle after reset, M1 sends 2 beats of 8'h3e, M2 sends 2 beats of 8'h4f -> M1 packet first, one idle cycle, then M2 packet. With both valid again, M1 is granted next (round-robin).
- s_ready toggles every 2 cycles during a 6-beat M2 packet -> no beat lost or duplicated, output order preserved, m2_ready=0 whenever the skid stage holds 2 entries.
- M1 packet of MAX_BEATS+2 = 18 beats -> len_err rises on beat 16 and stays high; all 18 beats delivered; beat_count ends at 18.
- reset pulsed for 1 cycle mid-packet (beat 2 of 4) with 2 beats buffered -> next cycle s_valid=0, grant=00, beat_count=0, len_err=0; the next request arbitrates with M1 priority.
- M2 owns the bus and m2_valid drops for 3 cycles mid-packet while m1_valid is high -> grant stays 10; m1_ready stays 0 until M2's last beat is accepted.
